// File: rtl/conv_loop_sequencer.sv
// Sequences the six convolution loop indices, one MAC term per accepted step,
// and decodes first/last/pad strobes plus the output-pixel address.
module conv_loop_sequencer #(
  parameter int CONV_DIM_IMG    = 32,
  parameter int CONV_DIM_KERNEL = 5,
  parameter int CONV_DIM_CH     = 3,
  parameter int CONV_OUT_CH     = 8,
  parameter int CONV_DIM_OUT    = 32,
  parameter int STRIDE          = 1,
  parameter int PADDING         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ready,
  output logic        busy,
  output logic        done,
  output logic        enable,
  output logic [7:0]  i,
  output logic [7:0]  j,
  output logic [7:0]  k,
  output logic [7:0]  l,
  output logic [7:0]  m,
  output logic [7:0]  n,
  output logic        pad,
  output logic        first,
  output logic        last,
  output logic [15:0] out_addr
);

  localparam logic [7:0] L_MAX = 8'(CONV_DIM_CH - 1);
  localparam logic [7:0] K_MAX = 8'(CONV_DIM_KERNEL - 1);
  localparam logic [7:0] O_MAX = 8'(CONV_DIM_OUT - 1);
  localparam logic [7:0] I_MAX = 8'(CONV_OUT_CH - 1);
  localparam int         OO    = CONV_DIM_OUT * CONV_DIM_OUT;
  localparam logic signed [17:0] S_W   = 18'(STRIDE);
  localparam logic signed [17:0] P_W   = 18'(PADDING);
  localparam logic signed [17:0] IMG_W = 18'(CONV_DIM_IMG);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [7:0] i, j, k, l, m, n;
  } idx_t;

  state_t state, state_nx;
  idx_t   idx, idx_nx;
  logic   c_l, c_n, c_m, c_k, c_j, terminal;
  logic signed [17:0] row, col;
  logic   pad_raw;

  // Carry chain, innermost first: l -> n -> m -> k -> j -> i.
  assign c_l      = (idx.l == L_MAX);
  assign c_n      = c_l & (idx.n == K_MAX);
  assign c_m      = c_n & (idx.m == K_MAX);
  assign c_k      = c_m & (idx.k == O_MAX);
  assign c_j      = c_k & (idx.j == O_MAX);
  assign terminal = c_j & (idx.i == I_MAX);

  always_comb begin
    idx_nx   = idx;
    idx_nx.l = c_l ? 8'd0 : idx.l + 8'd1;
    if (c_l) idx_nx.n = (idx.n == K_MAX) ? 8'd0 : idx.n + 8'd1;
    if (c_n) idx_nx.m = (idx.m == K_MAX) ? 8'd0 : idx.m + 8'd1;
    if (c_m) idx_nx.k = (idx.k == O_MAX) ? 8'd0 : idx.k + 8'd1;
    if (c_k) idx_nx.j = (idx.j == O_MAX) ? 8'd0 : idx.j + 8'd1;
    if (c_j) idx_nx.i = (idx.i == I_MAX) ? 8'd0 : idx.i + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 idx <= '0;
    else if (state == S_IDLE)   idx <= '0;
    else if (enable)            idx <= idx_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (enable && terminal) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // 18-bit signed so STRIDE*j + m - PADDING never wraps for 8-bit operands.
  assign row     = S_W * $signed({10'd0, idx.j}) + $signed({10'd0, idx.m}) - P_W;
  assign col     = S_W * $signed({10'd0, idx.k}) + $signed({10'd0, idx.n}) - P_W;
  assign pad_raw = (row < 0) || (row >= IMG_W) || (col < 0) || (col >= IMG_W);

  always_comb begin
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
    enable = (state == S_RUN) && ready;
    first  = enable && (idx.m == 8'd0) && (idx.n == 8'd0) && (idx.l == 8'd0);
    last   = enable && (idx.m == K_MAX) && (idx.n == K_MAX) && (idx.l == L_MAX);
    pad    = enable && pad_raw;
  end

  assign {i, j, k, l, m, n} = {idx.i, idx.j, idx.k, idx.l, idx.m, idx.n};
  assign out_addr = 16'(32'(idx.i) * OO + 32'(idx.j) * CONV_DIM_OUT + 32'(idx.k));

endmodule
